// File: rtl/shifter_pkg.sv
// Shared types and helpers for the round-robin shifter arbiter.
package shifter_pkg;

   typedef enum logic {EMPTY, FULL} arb_state_t;

   // Round-robin pointer advance: the slot after ptr, wrapping to 0 past nreq-1.
   function automatic int rr_next(input int ptr, input int nreq);
      return (ptr == nreq - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/param_left_shifter.sv
// Combinational left shifter: y = a << amt, truncated to W = 2**N bits, zero fill.
module param_left_shifter #(
   parameter int N = 2,
   localparam int W = 2**N
) (
   input  logic [W-1:0] a_i,
   input  logic [N-1:0] amt_i,
   output logic [W-1:0] y_o
);

   assign y_o = a_i << amt_i;

endmodule

// File: rtl/shifter_rr_arbiter.sv
// Round-robin arbiter sharing one left shifter among NREQ requesters; the winner's
// result is registered together with its id behind a valid/ready output handshake.
module shifter_rr_arbiter
   import shifter_pkg::*;
#(
   parameter int N    = 2,
   parameter int NREQ = 4,
   localparam int W   = 2**N,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ-1:0][W-1:0]   req_a,
   input  logic [NREQ-1:0][N-1:0]   req_amt,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [W-1:0]             res_y,
   output logic [IDW-1:0]           res_id
);

   arb_state_t     state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [W-1:0]   res_y_q, res_y_d;
   logic [IDW-1:0] res_id_q, res_id_d;

   logic           any_hi, any_lo;
   logic [IDW-1:0] hi_idx, lo_idx, grant_idx;
   logic           can_accept, grant;
   logic [W-1:0]   sel_a, shift_y;
   logic [N-1:0]   sel_amt;

   // Two-pass priority: first valid index at or above the pointer, else first below it.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves a latch.
      any_hi = 1'b0;
      any_lo = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i]) begin
            if (i >= int'(rr_ptr_q)) begin
               if (!any_hi) begin
                  any_hi = 1'b1;
                  hi_idx = IDW'(i);
               end
            end else if (!any_lo) begin
               any_lo = 1'b1;
               lo_idx = IDW'(i);
            end
         end
      end
      grant_idx = any_hi ? hi_idx : lo_idx;
   end

   // A full register that drains this cycle can be refilled in the same cycle.
   assign can_accept = !reset && ((state_q == EMPTY) || res_ready);
   assign grant      = can_accept && (|req_valid);

   always_comb begin
      sel_a     = '0;
      sel_amt   = '0;
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (i == int'(grant_idx)) begin
            sel_a        = req_a[i];
            sel_amt      = req_amt[i];
            req_ready[i] = grant;
         end
      end
   end

   param_left_shifter #(.N(N)) u_shifter (
      .a_i   (sel_a),
      .amt_i (sel_amt),
      .y_o   (shift_y)
   );

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      res_y_d  = res_y_q;
      res_id_d = res_id_q;
      if (grant) begin
         state_d  = FULL;
         res_y_d  = shift_y;
         res_id_d = grant_idx;
         rr_ptr_d = IDW'(rr_next(int'(grant_idx), NREQ));
      end else if (state_q == FULL && res_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q  <= EMPTY;
         rr_ptr_q <= '0;
         res_y_q  <= '0;
         res_id_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         res_y_q  <= res_y_d;
         res_id_q <= res_id_d;
      end
   end

   assign res_valid = (state_q == FULL);
   assign res_y     = res_y_q;
   assign res_id    = res_id_q;

endmodule

// File: tb/tb_shifter_rr_arbiter.sv
// Directed scoreboard bench for shifter_rr_arbiter (N=2, W=4, NREQ=4).
module tb_shifter_rr_arbiter;

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       req_valid;
   logic [3:0]       req_ready;
   logic [3:0][3:0]  req_a;
   logic [3:0][1:0]  req_amt;
   logic             res_valid;
   logic             res_ready;
   logic [3:0]       res_y;
   logic [1:0]       res_id;

   typedef struct packed {
      logic [3:0] y;
      logic [1:0] id;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   shifter_rr_arbiter #(.N(2), .NREQ(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_amt   (req_amt),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_y     (res_y),
      .res_id    (res_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [1:0] i, input logic [3:0] a, input logic [1:0] amt);
      req_a[i]   = a;
      req_amt[i] = amt;
   endtask

   task automatic push(input logic [3:0] y, input logic [1:0] id);
      sb.push_back('{y: y, id: id});
   endtask

   // Monitor: compares every result transfer against the oldest expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && res_valid && res_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: result y=%b id=%0d with no expected entry", res_y, res_id);
         end else begin
            e = sb.pop_front();
            check("res_y", 32'(res_y), 32'(e.y));
            check("res_id", 32'(res_id), 32'(e.id));
         end
      end
   end

   logic [3:0] rr_grant [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic [3:0] rr_y     [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1000};
   logic [3:0] bnd_grant[3] = '{4'b0010, 4'b0100, 4'b1000};
   logic [3:0] bnd_y    [3] = '{4'b1111, 4'b1000, 4'b1000};

   initial begin
      reset     = 1'b1;
      req_valid = 4'b1111;
      res_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_req(2'(i), 4'b0011, 2'(i));

      // Reset state, with requests pending
      @(negedge clk);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_y", 32'(res_y), 32'd0);
      check("rst_res_id", 32'(res_id), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);

      // Round-robin: all four valid, grants 0,1,2,3
      next_cycle();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) next_cycle();
         @(negedge clk);
         check("rr_grant", 32'(req_ready), 32'(rr_grant[c]));
         push(rr_y[c], 2'(c));
      end

      // Backpressure: FULL with 1000/id3 held for three cycles, no grants
      next_cycle();
      res_ready = 1'b0;
      for (int b = 0; b < 3; b++) begin
         if (b > 0) next_cycle();
         @(negedge clk);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         check("bp_res_valid", 32'(res_valid), 32'd1);
         check("bp_res_y", 32'(res_y), 32'b1000);
         check("bp_res_id", 32'(res_id), 32'd3);
      end

      // Release: same-cycle regrant to requester 0 (pointer wrapped)
      next_cycle();
      res_ready = 1'b1;
      @(negedge clk);
      check("regrant", 32'(req_ready), 32'b0001);
      push(4'b0011, 2'd0);

      // No bubble after refill, then drain-only
      next_cycle();
      req_valid = 4'b0000;
      @(negedge clk);
      check("no_bubble", 32'(res_valid), 32'd1);
      next_cycle();
      @(negedge clk);
      check("drain_res_valid", 32'(res_valid), 32'd0);
      check("drain_res_y", 32'(res_y), 32'b0011);
      check("drain_res_id", 32'(res_id), 32'd0);
      check("drain_req_ready", 32'(req_ready), 32'd0);

      // Single requester: 1001 << 1 = 0010
      next_cycle();
      set_req(2'd0, 4'b1001, 2'b01);
      req_valid = 4'b0001;
      @(negedge clk);
      check("single_grant", 32'(req_ready), 32'b0001);
      push(4'b0010, 2'd0);
      next_cycle();
      req_valid = 4'b0000;
      @(negedge clk);
      check("single_res_valid", 32'(res_valid), 32'd1);

      // Boundary amounts on requesters 1..3 (pointer now at 1)
      next_cycle();
      set_req(2'd1, 4'b1111, 2'b00);
      set_req(2'd2, 4'b1111, 2'b11);
      set_req(2'd3, 4'b0001, 2'b11);
      req_valid = 4'b1110;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) next_cycle();
         @(negedge clk);
         check("bnd_grant", 32'(req_ready), 32'(bnd_grant[k]));
         push(bnd_y[k], 2'(k + 1));
      end
      next_cycle();
      req_valid = 4'b0000;
      @(negedge clk);

      // Reset mid-stream: fill with requester 2 (pointer then 3), hold it, reset
      next_cycle();
      set_req(2'd2, 4'b0101, 2'b01);
      req_valid = 4'b0100;
      res_ready = 1'b0;
      @(negedge clk);
      check("pre_rst_grant", 32'(req_ready), 32'b0100);
      next_cycle();
      req_valid = 4'b0000;
      @(negedge clk);
      check("pre_rst_res_valid", 32'(res_valid), 32'd1);
      check("pre_rst_res_y", 32'(res_y), 32'b1010);
      check("pre_rst_res_id", 32'(res_id), 32'd2);
      #1;
      reset = 1'b1;
      #1;
      check("async_res_valid", 32'(res_valid), 32'd0);
      check("async_res_y", 32'(res_y), 32'd0);
      check("async_res_id", 32'(res_id), 32'd0);
      set_req(2'd1, 4'b0011, 2'b10);
      req_valid = 4'b1010;
      res_ready = 1'b1;
      #1;
      check("in_rst_req_ready", 32'(req_ready), 32'd0);
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_grant", 32'(req_ready), 32'b0010);
      push(4'b1100, 2'd1);
      next_cycle();
      req_valid = 4'b0000;
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
